// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32-iteration shift-add multiply and
// restoring divide over operand magnitudes, with sign fix-up in a final state.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mdcode,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  dst_in,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  dst_out
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic        spec_q, spec_d;
    logic [4:0]  dreg_q, dreg_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  dst_q, dst_d;

    logic        is_div, sa, sb, div0, ovf;
    logic [31:0] ma, mb, fix_val;
    logic [32:0] sum, rem_sh;
    logic [33:0] diff;
    logic [63:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        spec_d   = spec_q;
        dreg_d   = dreg_q;
        result_d = result_q;
        dst_d    = dst_q;

        is_div = mdcode[2];
        sa     = op1[31] & (mdcode == 3'd1 || mdcode == 3'd2 || mdcode == 3'd4 || mdcode == 3'd6);
        sb     = op2[31] & (mdcode == 3'd1 || mdcode == 3'd4 || mdcode == 3'd6);
        ma     = sa ? -op1 : op1;
        mb     = sb ? -op2 : op2;
        div0   = is_div && (op2 == 32'd0);
        ovf    = (mdcode == 3'd4 || mdcode == 3'd6) &&
                 (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

        // hi holds the partial product / running remainder, lo the multiplier / quotient
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        rem_sh = {hi_q, lo_q[31]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

        if (spec_q)
            fix_val = lo_q;
        else if (!op_q[2])
            fix_val = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
        else if (!op_q[1])
            fix_val = neg_q ? -lo_q : lo_q;
        else
            fix_val = neg_q ? -hi_q : hi_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d   = mdcode;
                    dreg_d = dst_in;
                    cnt_d  = 5'd0;
                    b_d    = mb;
                    hi_d   = 32'd0;
                    lo_d   = ma;
                    neg_d  = (is_div && mdcode[1]) ? sa : (sa ^ sb);
                    spec_d = 1'b0;
                    state_d = S_CALC;
                    if (div0) begin
                        spec_d  = 1'b1;
                        lo_d    = mdcode[1] ? op1 : 32'hFFFF_FFFF;
                        state_d = S_FIX;
                    end else if (ovf) begin
                        spec_d  = 1'b1;
                        lo_d    = mdcode[1] ? 32'd0 : 32'h8000_0000;
                        state_d = S_FIX;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    if (!diff[33]) begin
                        hi_d = diff[31:0];
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = rem_sh[31:0];
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else begin
                    hi_d = sum[32:1];
                    lo_d = {sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_val;
                dst_d    = dreg_q;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            dst_d    = dst_q;
        end

        busy = (state_q == S_IDLE && start && !flush) ||
               state_q == S_CALC || state_q == S_FIX;
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            dreg_q   <= '0;
            result_q <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            spec_q   <= spec_d;
            dreg_q   <= dreg_d;
            result_q <= result_d;
            dst_q    <= dst_d;
        end
    end

    assign result  = result_q;
    assign dst_out = dst_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latency, busy, flush and reset.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  mdcode;
    logic [31:0] op1, op2;
    logic [4:0]  dst_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  dst_out;

    int nvec = 0;
    int nerr = 0;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdcode(mdcode),
        .op1(op1), .op2(op2), .dst_in(dst_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .dst_out(dst_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op in the next IDLE cycle and check result, latency, busy span and done width.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dst,
                          input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        int nb  = 0;
        @(negedge clk);
        start = 1'b1; mdcode = op; op1 = a; op2 = b; dst_in = dst;
        #1 if (busy) nb++;
        @(posedge clk);
        #1 start = 1'b0;
        if (busy) nb++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nb++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, nb, exp_lat + 1);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_dst"}, {27'd0, dst_out}, {27'd0, dst});
        @(posedge clk);
        #1 chk({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] prev;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        mdcode = '0; op1 = '0; op2 = '0; dst_in = '0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_dst", {27'd0, dst_out}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33);
        run_op("mulh",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h8000_0000, 1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1);
        run_op("divu_z",  3'd5, 32'd100,        32'd0,         5'd7,  32'hFFFF_FFFF, 1);
        run_op("remu_z",  3'd7, 32'd100,        32'd0,         5'd8,  32'h0000_0064, 1);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33);
        run_op("divu_big",3'd5, 32'hFFFF_FFFE,  32'd2,         5'd11, 32'h7FFF_FFFF, 33);
        run_op("remu",    3'd7, 32'd100,        32'd7,         5'd12, 32'h0000_0002, 33);
        run_op("div_z",   3'd4, 32'hFFFF_FFF9,  32'd0,         5'd13, 32'hFFFF_FFFF, 1);
        run_op("rem_z",   3'd6, 32'hFFFF_FFF9,  32'd0,         5'd14, 32'hFFFF_FFF9, 1);

        // flush mid-divide
        prev = 32'hFFFF_FFF9;
        @(negedge clk);
        start = 1'b1; mdcode = 3'd4; op1 = 32'd100; op2 = 32'd7; dst_in = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_res", result, prev);
        chk("flush_dst", {27'd0, dst_out}, 32'd14);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        chk("flush_nodone", {31'd0, seen}, 32'd0);

        // start with flush in the same cycle is rejected
        @(negedge clk);
        start = 1'b1; flush = 1'b1; mdcode = 3'd0; op1 = 32'd2; op2 = 32'd2; dst_in = 5'd21;
        #1 chk("sflush_busy0", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("sflush_busy1", {31'd0, busy}, 32'd0);
        run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd22, 32'h0000_000E, 33);

        // reset mid-CALC
        @(negedge clk);
        start = 1'b1; mdcode = 3'd0; op1 = 32'd5; op2 = 32'd5; dst_in = 5'd23;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_res", result, 32'd0);
        chk("arst_dst", {27'd0, dst_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op("post_rst", 3'd0, 32'd3, 32'd4, 5'd9, 32'h0000_000C, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
